cmplx_mult_pipe: RTL and testbench
==================================

// Module: cmplx_mult_pipe
// PURPOSE
//   Pipelined, parametrised signed complex multiplier y = a * b (or a * conj(b)).
//   Streaming valid/ready on input and output; fixed-point rescale with rounding and saturation.
//   Drop-in datapath element for filter/FFT stages that need a registered,
//   back-pressurable complex multiply.
// PARAMETERS
//   WIDTH  8          operand/result width, two's-complement signed, per component
//   SHIFT  WIDTH-1    right shift applied to full products (Q1.(WIDTH-1) default)
//                     legal range 0..2*WIDTH
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand sample present
//   in_ready   out  1      block can accept; transfer when in_valid & in_ready
//   a_real     in   WIDTH  signed
//   a_img      in   WIDTH  signed
//   b_real     in   WIDTH  signed
//   b_img      in   WIDTH  signed
//   conj_b     in   1      1: use conj(b) (b_img negated), sampled with operands
//   out_valid  out  1      result present
//   out_ready  in   1      sink accepts; transfer when out_valid & out_ready
//   y_real     out  WIDTH  signed result, real part
//   y_img      out  WIDTH  signed result, imaginary part
//   out_sat    out  1      1 if either component of this result saturated
// BEHAVIOUR
//   Reset: v1=v2=v3=0; out_valid=0, y_real=0, y_img=0, out_sat=0.
//     in_ready=1 in the first cycle after reset release.
//   Pipeline, 3 register stages with valid bits v1,v2,v3; LATENCY=3:
//     S1 registers operands and conj_b.
//     S2 registers four 2*WIDTH signed products.
//       With conj_b the b_img term is negated in S2, by sign of the product.
//       Do not negate the operand: -(-2^(W-1)) would overflow.
//     S3 forms the sums, rounds, saturates, and registers the outputs.
//       The S3 registers drive the outputs directly.
//   Stall: en = ~v3 | out_ready. All stages advance together when en=1.
//     in_ready = en (combinational). No bubble compaction.
//     When en=0 all registers and outputs hold.
//   Timing: sample accepted at edge k -> out_valid=1 after edge k+2.
//     Full throughput of 1 sample/cycle with out_ready=1.
//   Arithmetic:
//     pr = ar*br - ai*bi'; pi = ar*bi' + ai*br, where bi' = +/-bi.
//     Sums are 2*WIDTH+1 bits signed; no intermediate overflow is possible.
//   Rounding (SHIFT>0): add 2^(SHIFT-1), then arithmetic shift right by SHIFT.
//     This is round-half-toward-+inf. SHIFT=0 means no rounding.
//   Saturation: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
//     out_sat = sat_real | sat_img, carried with the sample.
//   Simultaneous events:
//     Output pop and input push in the same cycle are both taken (en=1).
//     in_valid=0 while en=1 inserts a bubble (v1=0).
//   Reset mid-operation: all in-flight samples are discarded.
//     out_valid=0 from the cycle after the reset edge.
//     No stale result appears after release.
//   out_valid is never dropped without a transfer.
//   y_*/out_sat are stable while out_valid & ~out_ready.
// STRUCTURE
//   Shared package/header cmult_pkg:
//     LATENCY=3
//     function sat_clip(value, width)
//     rounding-constant macro
//   One sub-module, cmult_round_sat #(IN_W=2*WIDTH+1, WIDTH, SHIFT):
//     combinational round, shift and saturate; outputs value and sat flag.
//     Instantiated twice, for real and for imaginary.
// TESTING (WIDTH=8, SHIFT=7)
//   1 a=(64,0), b=(64,0), conj_b=0 -> y=(32,0), out_sat=0, 3 cycles after accept.
//   2 a=(0,64), b=(0,64): conj_b=0 -> y=(-32,0); conj_b=1 -> y=(32,0).
//   3 a=(-128,-128), b=(-128,-128) -> y=(0,127), out_sat=1.
//     Also a=(-128,0), b=(0,-128), conj_b=1 -> y=(0,-128), out_sat=0 (no operand negation overflow).
//   4 stream 8 random samples; hold out_ready=0 for 5 cycles mid-stream ->
//     in_ready=0 while v3 is held; outputs stable; all 8 results in order,
//     none lost or duplicated; match the golden model.
//   5 assert rst with 3 samples in flight -> out_valid=0 next cycle.
//     After release, only post-reset samples emerge.
//   6 continuous in_valid=1, out_ready=1, 1000 random samples ->
//     1 result/cycle after the 3-cycle fill; bit-exact vs the model.
//     Include SHIFT=0 and WIDTH=16 builds.

Source files
------------

// File: rtl/cmult_pkg.sv
// ---------------------------------------------------------------------------
// cmult_pkg
//   Shared constants and helpers for the pipelined complex multiplier.
//   LATENCY     : register stages from input transfer to output valid
//   round_const : bias added before the rounding right shift
//   sat_clip    : clamp a wide signed value to a signed field of 'width' bits
// ---------------------------------------------------------------------------
package cmult_pkg;

  localparam int LATENCY = 3;

  // 2^(shift-1) for shift > 0, zero otherwise. Adding this before an
  // arithmetic right shift gives round-half-toward-+inf.
  function automatic logic signed [63:0] round_const(input int shift);
    if (shift > 0) begin
      return 64'sd1 <<< (shift - 1);
    end
    return 64'sd0;
  endfunction

  // Clamp to [-2^(width-1), 2^(width-1)-1].
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) begin
      return hi;
    end
    if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/cmplx_mult_pipe_if.sv
// ---------------------------------------------------------------------------
// cmplx_mult_pipe_if
//   Streaming bundle for the complex multiplier.
//   Input side : in_valid/in_ready handshake, operands a_*, b_*, conj_b
//   Output side: out_valid/out_ready handshake, results y_*, out_sat
//   master : the producer/consumer environment around the multiplier
//   slave  : the multiplier itself
// ---------------------------------------------------------------------------
interface cmplx_mult_pipe_if #(
  parameter int WIDTH = 8
);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a_real;
  logic signed [WIDTH-1:0] a_img;
  logic signed [WIDTH-1:0] b_real;
  logic signed [WIDTH-1:0] b_img;
  logic                    conj_b;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] y_real;
  logic signed [WIDTH-1:0] y_img;
  logic                    out_sat;

  modport master (
    output in_valid, a_real, a_img, b_real, b_img, conj_b, out_ready,
    input  in_ready, out_valid, y_real, y_img, out_sat
  );

  modport slave (
    input  in_valid, a_real, a_img, b_real, b_img, conj_b, out_ready,
    output in_ready, out_valid, y_real, y_img, out_sat
  );

endinterface

// File: rtl/cmult_round_sat.sv
// ---------------------------------------------------------------------------
// cmult_round_sat
//   Combinational rescale of one wide signed sum to a WIDTH-bit result.
//   din  : IN_W-bit signed sum
//   dout : rounded (half toward +inf), shifted by SHIFT, saturated result
//   sat  : 1 when the clamp changed the value
// ---------------------------------------------------------------------------
module cmult_round_sat
  import cmult_pkg::*;
#(
  parameter int IN_W  = 17,
  parameter int WIDTH = 8,
  parameter int SHIFT = 7
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [WIDTH-1:0] dout,
  output logic                    sat
);

  // One guard bit so the rounding bias can never wrap the sum.
  localparam int EW = IN_W + 1;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] biased;
  logic signed [EW-1:0] shifted;
  logic signed [63:0]   wide;
  logic signed [63:0]   clipped;

  assign ext     = {din[IN_W-1], din};
  assign biased  = ext + EW'(round_const(SHIFT));
  assign shifted = biased >>> SHIFT;
  assign wide    = {{(64 - EW){shifted[EW-1]}}, shifted};
  assign clipped = sat_clip(wide, WIDTH);
  assign dout    = clipped[WIDTH-1:0];
  assign sat     = (clipped != wide);

endmodule

// File: rtl/cmplx_mult_pipe.sv
// ---------------------------------------------------------------------------
// cmplx_mult_pipe
//   Three-stage pipelined signed complex multiplier, y = a*b or a*conj(b),
//   with valid/ready streaming on both sides and round/saturate rescale.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, flushes all in-flight samples
//   bus : cmplx_mult_pipe_if slave (operands in, results out)
//   Stage 1 registers operands, stage 2 the four partial products, stage 3
//   the rescaled results, which drive the outputs directly. All stages
//   advance together whenever the output register is empty or being read.
// ---------------------------------------------------------------------------
module cmplx_mult_pipe
  import cmult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = WIDTH - 1
) (
  input logic              clk,
  input logic              rst,
  cmplx_mult_pipe_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam int SW = 2 * WIDTH + 1;

  logic en;

  logic                    v1_reg;
  logic                    v2_reg;
  logic                    v3_reg;
  logic signed [WIDTH-1:0] ar1_reg;
  logic signed [WIDTH-1:0] ai1_reg;
  logic signed [WIDTH-1:0] br1_reg;
  logic signed [WIDTH-1:0] bi1_reg;
  logic                    conj1_reg;

  logic signed [PW-1:0] p_rr;
  logic signed [PW-1:0] p_ir;
  logic signed [PW-1:0] p_ii_raw;
  logic signed [PW-1:0] p_ri_raw;
  logic signed [PW-1:0] p_ii;
  logic signed [PW-1:0] p_ri;
  logic signed [PW-1:0] p_rr_reg;
  logic signed [PW-1:0] p_ir_reg;
  logic signed [PW-1:0] p_ii_reg;
  logic signed [PW-1:0] p_ri_reg;

  logic signed [SW-1:0]    sum    [2];
  logic signed [WIDTH-1:0] rs_val [2];
  logic                    rs_sat [2];

  logic signed [WIDTH-1:0] y_real_reg;
  logic signed [WIDTH-1:0] y_img_reg;
  logic                    sat_reg;

  // Whole pipe moves when the output slot is free or is being consumed.
  assign en           = ~v3_reg | bus.out_ready;
  assign bus.in_ready = en;

  assign p_rr     = PW'(ar1_reg) * PW'(br1_reg);
  assign p_ir     = PW'(ai1_reg) * PW'(br1_reg);
  assign p_ii_raw = PW'(ai1_reg) * PW'(bi1_reg);
  assign p_ri_raw = PW'(ar1_reg) * PW'(bi1_reg);

  // Conjugation flips the sign of the b_img products rather than b_img
  // itself: negating a most-negative operand would overflow WIDTH bits,
  // whereas every product negation fits in 2*WIDTH bits.
  assign p_ii = conj1_reg ? -p_ii_raw : p_ii_raw;
  assign p_ri = conj1_reg ? -p_ri_raw : p_ri_raw;

  // One extra bit holds any sum/difference of two products exactly.
  assign sum[0] = SW'(p_rr_reg) - SW'(p_ii_reg);
  assign sum[1] = SW'(p_ri_reg) + SW'(p_ir_reg);

  // Index 0 = real part, index 1 = imaginary part.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rs
      cmult_round_sat #(
        .IN_W  (SW),
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
      ) u_round_sat (
        .din  (sum[gi]),
        .dout (rs_val[gi]),
        .sat  (rs_sat[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg     <= 1'b0;
      v2_reg     <= 1'b0;
      v3_reg     <= 1'b0;
      ar1_reg    <= '0;
      ai1_reg    <= '0;
      br1_reg    <= '0;
      bi1_reg    <= '0;
      conj1_reg  <= 1'b0;
      p_rr_reg   <= '0;
      p_ir_reg   <= '0;
      p_ii_reg   <= '0;
      p_ri_reg   <= '0;
      y_real_reg <= '0;
      y_img_reg  <= '0;
      sat_reg    <= 1'b0;
    end else if (en) begin
      // Stage 1: an idle input cycle becomes a bubble (v1 = 0).
      v1_reg     <= bus.in_valid;
      ar1_reg    <= bus.a_real;
      ai1_reg    <= bus.a_img;
      br1_reg    <= bus.b_real;
      bi1_reg    <= bus.b_img;
      conj1_reg  <= bus.conj_b;
      // Stage 2
      v2_reg     <= v1_reg;
      p_rr_reg   <= p_rr;
      p_ir_reg   <= p_ir;
      p_ii_reg   <= p_ii;
      p_ri_reg   <= p_ri;
      // Stage 3
      v3_reg     <= v2_reg;
      y_real_reg <= rs_val[0];
      y_img_reg  <= rs_val[1];
      sat_reg    <= rs_sat[0] | rs_sat[1];
    end
  end

  assign bus.out_valid = v3_reg;
  assign bus.y_real    = y_real_reg;
  assign bus.y_img     = y_img_reg;
  assign bus.out_sat   = sat_reg;

endmodule

// File: tb/tb_cmplx_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_cmplx_mult_pipe
//   Self-checking bench for cmplx_mult_pipe. A main WIDTH=8/SHIFT=7 instance
//   runs directed, back-pressure, reset and streaming tests; two extra builds
//   (WIDTH=8/SHIFT=0 and WIDTH=16/SHIFT=15) run random streams in parallel.
//   Expected results come from an integer reference model.
// ---------------------------------------------------------------------------
module tb_cmplx_mult_pipe;

  localparam int W = 8;
  localparam int S = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  cmplx_mult_pipe_if #(.WIDTH(W)) bus ();

  cmplx_mult_pipe #(.WIDTH(W), .SHIFT(S)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    longint yr;
    longint yi;
    bit     sat;
  } res_t;

  function automatic longint rnd_shift(input longint v, input int s);
    if (s == 0) return v;
    return (v + (longint'(1) <<< (s - 1))) >>> s;
  endfunction

  // Plain integer complex multiply, rescale, clamp.
  function automatic res_t ref_model(input longint ar, input longint ai,
                                     input longint br, input longint bi,
                                     input bit cj, input int w, input int s);
    res_t   r;
    longint bim, pr, pi, hi, lo, yr, yi;
    bim   = cj ? -bi : bi;
    pr    = ar * br - ai * bim;
    pi    = ar * bim + ai * br;
    hi    = (longint'(1) <<< (w - 1)) - 1;
    lo    = -hi - 1;
    yr    = rnd_shift(pr, s);
    yi    = rnd_shift(pi, s);
    r.sat = (yr > hi) || (yr < lo) || (yi > hi) || (yi < lo);
    r.yr  = (yr > hi) ? hi : ((yr < lo) ? lo : yr);
    r.yi  = (yi > hi) ? hi : ((yi < lo) ? lo : yi);
    return r;
  endfunction

  // Random operand with extra weight on the two extreme values.
  function automatic longint rand_op(input int w);
    int     sel;
    longint hi;
    sel = int'($urandom_range(0, 7));
    hi  = (longint'(1) <<< (w - 1)) - 1;
    if (sel == 0) return -hi - 1;
    if (sel == 1) return hi;
    return longint'($urandom_range(0, int'(2 * hi + 1))) - (hi + 1);
  endfunction

  task automatic set_ops(input longint ar, input longint ai, input longint br,
                         input longint bi, input bit cj);
    bus.a_real = W'(ar);
    bus.a_img  = W'(ai);
    bus.b_real = W'(br);
    bus.b_img  = W'(bi);
    bus.conj_b = cj;
  endtask

  task automatic set_random_ops();
    set_ops(rand_op(W), rand_op(W), rand_op(W), rand_op(W), 1'($urandom_range(0, 1)));
  endtask

  // Holds in_valid until the sample is taken; called #1 after an edge.
  task automatic push_sample(input string tag);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check({tag, "_accept_timeout"}, 0, 1);
  endtask

  // ---------------- main scoreboard / monitor ----------------
  res_t exp_q[$];
  int   rx_count = 0;

  initial begin : main_monitor
    res_t                 e;
    bit                   prev_stall;
    logic signed [W-1:0]  hold_r, hold_i;
    logic                 hold_s;
    prev_stall = 1'b0;
    hold_r     = '0;
    hold_i     = '0;
    hold_s     = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_out_valid", bus.out_valid, 1);
          check("hold_y_real", bus.y_real, hold_r);
          check("hold_y_img", bus.y_img, hold_i);
          check("hold_out_sat", bus.out_sat, hold_s);
        end
        if (bus.out_valid && !bus.out_ready) check("stall_in_ready", bus.in_ready, 0);
        prev_stall = bus.out_valid && !bus.out_ready;
        hold_r     = bus.y_real;
        hold_i     = bus.y_img;
        hold_s     = bus.out_sat;
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("model_y_real", bus.y_real, e.yr);
            check("model_y_img", bus.y_img, e.yi);
            check("model_out_sat", bus.out_sat, e.sat);
          end
          $display("txn main n=%0d y=(%0d,%0d) sat=%0d", rx_count, bus.y_real, bus.y_img, bus.out_sat);
          rx_count++;
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(ref_model(bus.a_real, bus.a_img, bus.b_real, bus.b_img,
                                    bus.conj_b, W, S));
      end
    end
  end

  // One directed sample into an empty pipe with out_ready=1; checks the
  // 3-edge latency and literal expected values. Called #1 after an edge.
  task automatic directed(input string tag, input longint ar, input longint ai,
                          input longint br, input longint bi, input bit cj,
                          input longint er, input longint ei, input bit es);
    set_ops(ar, ai, br, bi, cj);
    bus.in_valid = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_valid_k"}, bus.out_valid, 0);
    @(posedge clk);
    #1;
    check({tag, "_valid_k1"}, bus.out_valid, 0);
    @(posedge clk);
    #1;
    check({tag, "_valid_k2"}, bus.out_valid, 1);
    check({tag, "_y_real"}, bus.y_real, er);
    check({tag, "_y_img"}, bus.y_img, ei);
    check({tag, "_out_sat"}, bus.out_sat, es);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input string tag, input int target);
    int n;
    n = 0;
    while (rx_count < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_rx_count"}, rx_count, target);
  endtask

  // ---------------- extra builds: random streams ----------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_build
      localparam int CW = (gi == 0) ? 8 : 16;
      localparam int CS = (gi == 0) ? 0 : 15;

      logic rst_b;
      bit   done_b = 1'b0;
      res_t q[$];
      int   rx = 0;

      cmplx_mult_pipe_if #(.WIDTH(CW)) xbus ();

      cmplx_mult_pipe #(.WIDTH(CW), .SHIFT(CS)) u_dut (
        .clk (clk),
        .rst (rst_b),
        .bus (xbus)
      );

      initial begin : drive
        int vc;
        rst_b          = 1'b1;
        xbus.in_valid  = 1'b0;
        xbus.out_ready = 1'b1;
        xbus.a_real    = '0;
        xbus.a_img     = '0;
        xbus.b_real    = '0;
        xbus.b_img     = '0;
        xbus.conj_b    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("b%0d_rst_out_valid", gi), xbus.out_valid, 0);
        rst_b = 1'b0;
        vc    = 0;
        for (int i = 0; i < 1000; i++) begin
          xbus.a_real   = CW'(rand_op(CW));
          xbus.a_img    = CW'(rand_op(CW));
          xbus.b_real   = CW'(rand_op(CW));
          xbus.b_img    = CW'(rand_op(CW));
          xbus.conj_b   = 1'($urandom_range(0, 1));
          xbus.in_valid = 1'b1;
          @(posedge clk);
          #1;
          if (i >= 2 && xbus.out_valid) vc++;
        end
        xbus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check($sformatf("b%0d_throughput", gi), vc, 998);
        check($sformatf("b%0d_rx_count", gi), rx, 1000);
        done_b = 1'b1;
      end

      initial begin : mon
        res_t e;
        forever begin
          @(negedge clk);
          if (rst_b) begin
            q.delete();
          end else begin
            if (xbus.out_valid && xbus.out_ready) begin
              if (q.size() == 0) begin
                check($sformatf("b%0d_unexpected_output", gi), 1, 0);
              end else begin
                e = q.pop_front();
                check($sformatf("b%0d_y_real", gi), xbus.y_real, e.yr);
                check($sformatf("b%0d_y_img", gi), xbus.y_img, e.yi);
                check($sformatf("b%0d_out_sat", gi), xbus.out_sat, e.sat);
              end
              $display("txn b%0d n=%0d y=(%0d,%0d) sat=%0d", gi, rx, xbus.y_real, xbus.y_img, xbus.out_sat);
              rx++;
            end
            if (xbus.in_valid && xbus.in_ready)
              q.push_back(ref_model(xbus.a_real, xbus.a_img, xbus.b_real, xbus.b_img,
                                    xbus.conj_b, CW, CS));
          end
        end
      end
    end
  endgenerate

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test sequence ----------------
  initial begin : main_seq
    int rx_before;
    int vcount;
    int n;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_ops(0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_y_real", bus.y_real, 0);
    check("rst_y_img", bus.y_img, 0);
    check("rst_out_sat", bus.out_sat, 0);
    rst = 1'b0;
    check("rst_in_ready", bus.in_ready, 1);

    // Directed products (Q1.7)
    directed("t1_real", 64, 0, 64, 0, 1'b0, 32, 0, 1'b0);
    directed("t2_imag", 0, 64, 0, 64, 1'b0, -32, 0, 1'b0);
    directed("t2_conj", 0, 64, 0, 64, 1'b1, 32, 0, 1'b0);
    directed("t3_sat", -128, -128, -128, -128, 1'b0, 0, 127, 1'b1);
    directed("t3_conj_min", -128, 0, 0, -128, 1'b1, 0, -128, 1'b0);

    // Back-pressure: 8 samples, out_ready low for 5 cycles mid-stream
    rx_before = rx_count;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          set_random_ops();
          bus.in_valid = 1'b1;
          push_sample("t4");
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    wait_rx("t4", rx_before + 8);
    check("t4_queue_empty", exp_q.size(), 0);

    // Reset with three samples in flight
    rx_before = rx_count;
    for (int i = 0; i < 3; i++) begin
      set_random_ops();
      bus.in_valid = 1'b1;
      push_sample("t5_fill");
    end
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("t5_valid_after_rst", bus.out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_stale", bus.out_valid, 0);
      @(posedge clk);
      #1;
    end
    check("t5_discarded", rx_count, rx_before);
    for (int i = 0; i < 2; i++) begin
      set_random_ops();
      bus.in_valid = 1'b1;
      push_sample("t5_post");
    end
    bus.in_valid = 1'b0;
    wait_rx("t5", rx_before + 2);

    // Continuous streaming, 1000 samples
    rx_before     = rx_count;
    bus.out_ready = 1'b1;
    vcount        = 0;
    for (int i = 0; i < 1000; i++) begin
      set_random_ops();
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      if (i >= 2 && bus.out_valid) vcount++;
    end
    bus.in_valid = 1'b0;
    wait_rx("t6", rx_before + 1000);
    check("t6_throughput", vcount, 998);

    // Let the extra builds finish
    n = 0;
    while (!(g_build[0].done_b && g_build[1].done_b) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check("builds_done", {31'd0, g_build[0].done_b & g_build[1].done_b}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
